cycle_shadow_buffer: RTL and testbench

- Successor to the per-transducer cycle pipeline for the PWM path.
- Holds per-channel PWM cycle values in a shadow bank written over a simple word-write bus.
- Commits the shadow bank atomically into an active bank on a sync boundary, after an explicit update request.
- Publishes the active cycles plus NUM_TAPS registered decremented copies (cycle-1 … cycle-NUM_TAPS) to the PWM timers.

---
 rtl/cycle_buffer_pkg.sv | 9 +
 rtl/cycle_tap_gen.sv | 16 +
 rtl/cycle_shadow_buffer.sv | 70 +++++++
 tb/tb_cycle_shadow_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cycle_buffer_pkg.sv
// cycle_buffer_pkg: shared types, reset constant and write clamp for the cycle shadow buffer
package cycle_buffer_pkg;
   typedef logic [12:0] cycle_t;
   localparam cycle_t DEFAULT_CYCLE_13 = 13'd4096;
   typedef enum logic {IDLE, PENDING} state_t;
   function automatic logic [31:0] clamp_cycle(input logic [31:0] v, input logic [31:0] lo);
      return v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/cycle_tap_gen.sv
// cycle_tap_gen: registers NUM_TAPS decremented copies (cycle-1 .. cycle-NUM_TAPS) of one channel
module cycle_tap_gen #(
   parameter int WIDTH = 13,
   parameter int NUM_TAPS = 2,
   parameter int DEFAULT_CYCLE = 4096
) (
   input  logic CLK,
   input  logic RST,
   input  logic [WIDTH-1:0] CYCLE,
   output logic [NUM_TAPS-1:0][WIDTH-1:0] CYCLE_M
);
   // modulo-2^WIDTH subtraction; wrap-around is intentional
   always_ff @(posedge CLK)
      for (int k = 0; k < NUM_TAPS; k++)
         CYCLE_M[k] <= RST ? WIDTH'(DEFAULT_CYCLE - k - 1) : CYCLE - WIDTH'(k + 1);
endmodule

// File: rtl/cycle_shadow_buffer.sv
// cycle_shadow_buffer: shadow/active PWM cycle banks with armed commit on SYNC and decremented taps
// Optional write clamp to MIN_CYCLE when CYCLE_SHADOW_BUFFER_CLAMP_EN is defined.
module cycle_shadow_buffer
   import cycle_buffer_pkg::*;
#(
   parameter int WIDTH = 13,
   parameter int DEPTH = 249,
   parameter int NUM_TAPS = 2,
   parameter int DEFAULT_CYCLE = 4096,
   parameter int MIN_CYCLE = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic WE,
   input  logic [$clog2(DEPTH)-1:0] ADDR,
   input  logic [WIDTH-1:0] DIN,
   input  logic UPDATE_REQ,
   input  logic SYNC,
   output logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
   output logic [NUM_TAPS-1:0][DEPTH-1:0][WIDTH-1:0] CYCLE_M,
   output logic PENDING,
   output logic UPDATED,
   output logic CLAMPED
);
   localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_CYCLE);
   if (NUM_TAPS < 1 || NUM_TAPS > 4 || MIN_CYCLE < 0) begin : g_bad_params
      $error("cycle_shadow_buffer: illegal NUM_TAPS or MIN_CYCLE");
   end
   logic [DEPTH-1:0][WIDTH-1:0] shadow;
   logic [WIDTH-1:0] wdata;
   state_t state;
   logic commit, commit_q, wr_ok;
   assign commit = state == cycle_buffer_pkg::PENDING && SYNC;
   assign wr_ok = WE && 32'(ADDR) < DEPTH;
   assign PENDING = state == cycle_buffer_pkg::PENDING;
`ifdef CYCLE_SHADOW_BUFFER_CLAMP_EN
   assign wdata = WIDTH'(clamp_cycle(32'(DIN), 32'(MIN_CYCLE)));
   always_ff @(posedge CLK)
      if (RST) CLAMPED <= 1'b0;
      else if (wr_ok && 32'(DIN) < MIN_CYCLE) CLAMPED <= 1'b1;
`else
   assign wdata = DIN;
   assign CLAMPED = 1'b0;
`endif
   // commit copies pre-write shadow; a same-cycle write lands afterwards
   always_ff @(posedge CLK) begin
      if (RST) begin
         shadow <= {DEPTH{DEF}};
         CYCLE <= {DEPTH{DEF}};
         state <= IDLE;
         commit_q <= 1'b0;
         UPDATED <= 1'b0;
      end else begin
         if (commit) CYCLE <= shadow;
         if (wr_ok) shadow[ADDR] <= wdata;
         state <= state == IDLE ? (UPDATE_REQ ? cycle_buffer_pkg::PENDING : IDLE)
                                : (SYNC ? IDLE : cycle_buffer_pkg::PENDING);
         commit_q <= commit;
         UPDATED <= commit_q;
      end
   end
   for (genvar i = 0; i < DEPTH; i++) begin : g_ch
      logic [NUM_TAPS-1:0][WIDTH-1:0] m;
      cycle_tap_gen #(.WIDTH(WIDTH), .NUM_TAPS(NUM_TAPS), .DEFAULT_CYCLE(DEFAULT_CYCLE)) u_tap (
         .CLK(CLK), .RST(RST), .CYCLE(CYCLE[i]), .CYCLE_M(m));
      for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
         assign CYCLE_M[k][i] = m[k];
      end
   end
endmodule

// File: tb/tb_cycle_shadow_buffer.sv
// tb_cycle_shadow_buffer: directed plus random checks of cycle_shadow_buffer against a bank model
module tb_cycle_shadow_buffer;
   localparam int W = 13, D = 249, T = 2, DEF = 4096;
   logic CLK = 1'b0, RST = 1'b0, WE = 1'b0, UPDATE_REQ = 1'b0, SYNC = 1'b0;
   logic [7:0] ADDR = '0;
   logic [W-1:0] DIN = '0;
   logic [D-1:0][W-1:0] CYCLE;
   logic [T-1:0][D-1:0][W-1:0] CYCLE_M;
   logic PENDING, UPDATED, CLAMPED;
   int vectors = 0, miscompares = 0;
   int sh[D], act[D], msrc[D];
   bit pend, upd, upd_nx, clamped;

   cycle_shadow_buffer dut (.CLK(CLK), .RST(RST), .WE(WE), .ADDR(ADDR), .DIN(DIN),
      .UPDATE_REQ(UPDATE_REQ), .SYNC(SYNC), .CYCLE(CYCLE), .CYCLE_M(CYCLE_M),
      .PENDING(PENDING), .UPDATED(UPDATED), .CLAMPED(CLAMPED));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [D-1:0][W-1:0] ec;
      logic [T-1:0][D-1:0][W-1:0] em;
      for (int i = 0; i < D; i++) begin
         ec[i] = W'(act[i]);
         for (int k = 0; k < T; k++) em[k][i] = W'(msrc[i] - k - 1);
      end
      vectors++;
      assert (CYCLE === ec) else begin
         miscompares++;
         for (int i = 0; i < D; i++)
            if (CYCLE[i] !== ec[i]) begin
               $error("FAIL cycle ch%0d: observed %0d expected %0d", i, CYCLE[i], ec[i]);
               break;
            end
      end
      vectors++;
      assert (CYCLE_M === em) else begin
         miscompares++;
         for (int k = 0; k < T; k++)
            for (int i = 0; i < D; i++)
               if (CYCLE_M[k][i] !== em[k][i])
                  $error("FAIL cycle_m tap%0d ch%0d: observed %0d expected %0d", k, i, CYCLE_M[k][i], em[k][i]);
      end
      chk("pending", 32'(PENDING), 32'(pend));
      chk("updated", 32'(UPDATED), 32'(upd));
      chk("clamped", 32'(CLAMPED), 32'(clamped));
   endtask

   task automatic step(input bit r, input bit we, input int a, input int d, input bit req, input bit sy);
      bit commit;
      int v;
      RST = r; WE = we; ADDR = 8'(a); DIN = W'(d); UPDATE_REQ = req; SYNC = sy;
      @(posedge CLK);
      commit = !r && pend && sy;
      for (int i = 0; i < D; i++) msrc[i] = r ? DEF : act[i];
      upd = !r && upd_nx;
      upd_nx = commit;
      if (r) begin
         foreach (sh[i]) begin sh[i] = DEF; act[i] = DEF; end
         pend = 0;
         clamped = 0;
      end else begin
         if (commit) act = sh;
         if (we && a < D) begin
            v = d % (1 << W);
`ifdef CYCLE_SHADOW_BUFFER_CLAMP_EN
            if (v < 2) begin v = 2; clamped = 1; end
`endif
            sh[a] = v;
         end
         pend = pend ? !sy : req;
      end
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0);
      idle(5);
      chk("rst_cycle3", 32'(CYCLE[3]), 4096);
      chk("rst_m0_ch3", 32'(CYCLE_M[0][3]), 4095);
      chk("rst_m1_ch3", 32'(CYCLE_M[1][3]), 4094);
      chk("rst_pending", 32'(PENDING), 0);
      chk("rst_updated", 32'(UPDATED), 0);
      step(0, 1, 3, 1000, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 1);
      chk("commit_cycle3", 32'(CYCLE[3]), 1000);
      chk("commit_m0_old", 32'(CYCLE_M[0][3]), 4095);
      chk("commit_updated_t", 32'(UPDATED), 0);
      idle(1);
      chk("t1_m0_ch3", 32'(CYCLE_M[0][3]), 999);
      chk("t1_m1_ch3", 32'(CYCLE_M[1][3]), 998);
      chk("t1_updated", 32'(UPDATED), 1);
      chk("t1_other_ch", 32'(CYCLE[4]), 4096);
      idle(1);
      chk("t2_updated", 32'(UPDATED), 0);
      step(0, 1, 5, 2000, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      chk("arm_only_pending", 32'(PENDING), 1);
      chk("arm_only_cycle5", 32'(CYCLE[5]), 4096);
      step(0, 0, 0, 0, 0, 1);
      chk("arm_then_sync_cycle5", 32'(CYCLE[5]), 2000);
      step(0, 0, 0, 0, 1, 0);
      step(0, 1, 7, 500, 0, 1);
      chk("commit_write_cycle7", 32'(CYCLE[7]), 4096);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("second_commit_cycle7", 32'(CYCLE[7]), 500);
      step(0, 1, 249, 77, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("oob_cycle248", 32'(CYCLE[248]), 4096);
      step(0, 1, 9, 321, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_mid_pending", 32'(PENDING), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_mid_cycle9", 32'(CYCLE[9]), 4096);
      step(0, 1, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1);
      idle(1);
`ifdef CYCLE_SHADOW_BUFFER_CLAMP_EN
      chk("clamp_cycle0", 32'(CYCLE[0]), 2);
      chk("clamp_m1_ch0", 32'(CYCLE_M[1][0]), 0);
      chk("clamp_flag", 32'(CLAMPED), 1);
`else
      chk("raw_cycle0", 32'(CYCLE[0]), 1);
      chk("raw_m1_ch0", 32'(CYCLE_M[1][0]), 8191);
      chk("raw_flag", 32'(CLAMPED), 0);
`endif
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      for (int n = 0; n < 1500; n++)
         step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 255),
              $urandom_range(0, 3) == 0 ? $urandom_range(0, 4) : $urandom_range(0, 8191),
              $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
